// File: rtl/cbus_axi_arbiter_pkg.sv
// Shared cache-bus/AXI types for the cache-side interconnect.
// Request/response structs, burst encodings and the arbiter FSM state enum.
package common;

    typedef logic [7:0] mlen_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [63:0] addr;
        logic [2:0]  size;
        mlen_t       len;
        logic [63:0] data;
        logic [7:0]  strb;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        CBUS_ARB_IDLE,
        CBUS_ARB_ADDR,
        CBUS_ARB_DATA,
        CBUS_ARB_RESP
    } cbus_arb_state_t;

endpackage

// File: rtl/cbus_axi_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, scanning cyclically.
// Latency: purely combinational. Backpressure: none, caller decides when to sample.
// Reused by other interconnect blocks, so it carries no state of its own.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] gnt,
    output logic          any
);

    int idx;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        gnt = '0;
        idx = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                gnt = PW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cbus_axi_arbiter.sv
// Round-robin arbiter of NUM_PORTS cache-bus masters onto one AXI4 master port.
// Latency: AR/AW one cycle after grant; writes complete only on the B response.
// Backpressure: follows AXI ready/valid; optional sticky error flags under CBUS_AXI_ERR_EN.
module cbus_axi_arbiter
    import common::*;
#(
    parameter int         NUM_PORTS = 2,
    parameter int         ID_BASE   = 0,
    parameter logic [1:0] BURST     = AXI_BURST_WRAP
) (
    input  logic              aclk,
    input  logic              areset,
    // AR
    output logic [3:0]        arid,
    output logic [63:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // R
    input  logic [3:0]        rid,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AW
    output logic [3:0]        awid,
    output logic [63:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    // W
    output logic [63:0]       wdata,
    output logic [7:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // B
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    // cache-bus ports
    input  cbus_req_t         creqs  [NUM_PORTS],
    output cbus_resp_t        cresps [NUM_PORTS],
    output logic [NUM_PORTS-1:0] cerr
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    cbus_arb_state_t state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    mlen_t           count_q, count_d;
    cbus_req_t       saved_req_q, saved_req_d;

    logic [NUM_PORTS-1:0] req_vld;
    logic [PW-1:0]        arb_gnt;
    logic                 arb_any;
    logic [PW-1:0]        rr_next;
    logic [3:0]           axi_id;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_vld[i] = creqs[i].valid;
        end
    end

    rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_rr_arbiter (
        .req (req_vld),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    assign rr_next = (gnt_q == PW'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
    assign axi_id  = 4'(ID_BASE) + 4'(gnt_q);

    assign arlock  = 1'b0;
    assign arcache = '0;
    assign arprot  = '0;
    assign awlock  = 1'b0;
    assign awcache = '0;
    assign awprot  = '0;

`ifdef CBUS_AXI_ERR_EN
    logic [NUM_PORTS-1:0] cerr_q, cerr_d;
    assign cerr = cerr_q;
`else
    assign cerr = '0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        count_d     = count_q;
        saved_req_d = saved_req_q;
`ifdef CBUS_AXI_ERR_EN
        cerr_d      = cerr_q;
`endif
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0;
        bready = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cresps[i] = '0;
        end

        case (state_q)
            CBUS_ARB_IDLE: begin
                if (arb_any) begin
                    saved_req_d = creqs[arb_gnt];
                    gnt_d       = arb_gnt;
                    count_d     = creqs[arb_gnt].len;
                    state_d     = CBUS_ARB_ADDR;
                end
            end
            CBUS_ARB_ADDR: begin
                if (saved_req_q.is_write) begin
                    awvalid = 1'b1;
                    awid    = axi_id;
                    awaddr  = saved_req_q.addr;
                    awlen   = saved_req_q.len;
                    awsize  = saved_req_q.size;
                    awburst = BURST;
                    if (awready) state_d = CBUS_ARB_DATA;
                end else begin
                    arvalid = 1'b1;
                    arid    = axi_id;
                    araddr  = saved_req_q.addr;
                    arlen   = saved_req_q.len;
                    arsize  = saved_req_q.size;
                    arburst = BURST;
                    if (arready) state_d = CBUS_ARB_DATA;
                end
            end
            CBUS_ARB_DATA: begin
                if (saved_req_q.is_write) begin
                    // Write data is taken live so the port can stream beats as they are accepted.
                    wvalid = 1'b1;
                    wdata  = creqs[gnt_q].data;
                    wstrb  = creqs[gnt_q].strb;
                    wlast  = (count_q == '0);
                    if (wready) begin
                        if (count_q == '0) begin
                            state_d = CBUS_ARB_RESP;
                        end else begin
                            cresps[gnt_q].ready = 1'b1;
                            count_d = count_q - 8'd1;
                        end
                    end
                end else begin
                    rready = 1'b1;
                    if (rvalid) begin
                        cresps[gnt_q].ready = 1'b1;
                        cresps[gnt_q].data  = rdata;
`ifdef CBUS_AXI_ERR_EN
                        if (rresp != 2'b00) cerr_d[gnt_q] = 1'b1;
`endif
                        if (rlast && count_q == '0) begin
                            cresps[gnt_q].last = 1'b1;
                            state_d  = CBUS_ARB_IDLE;
                            rr_ptr_d = rr_next;
                        end else begin
                            count_d = count_q - 8'd1;
                        end
                    end
                end
            end
            CBUS_ARB_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    cresps[gnt_q].ready = 1'b1;
                    cresps[gnt_q].last  = 1'b1;
`ifdef CBUS_AXI_ERR_EN
                    if (bresp != 2'b00) cerr_d[gnt_q] = 1'b1;
`endif
                    state_d  = CBUS_ARB_IDLE;
                    rr_ptr_d = rr_next;
                end
            end
            default: state_d = CBUS_ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= CBUS_ARB_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            count_q     <= '0;
            saved_req_q <= '0;
`ifdef CBUS_AXI_ERR_EN
            cerr_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            count_q     <= count_d;
            saved_req_q <= saved_req_d;
`ifdef CBUS_AXI_ERR_EN
            cerr_q      <= cerr_d;
`endif
        end
    end

    // Response IDs are not checked; write payload of the saved copy is never used.
    logic unused_ok;
`ifdef CBUS_AXI_ERR_EN
    assign unused_ok = ^{rid, bid, saved_req_q.valid, saved_req_q.data, saved_req_q.strb};
`else
    assign unused_ok = ^{rid, bid, rresp, bresp, saved_req_q.valid, saved_req_q.data,
                         saved_req_q.strb};
`endif

endmodule

// File: tb/tb_cbus_axi_arbiter.sv
// Directed bench for cbus_axi_arbiter with two ports and ID_BASE = 2.
module tb_cbus_axi_arbiter;
    import common::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  arid, awid, rid, bid;
    logic [63:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic [3:0]  arcache, awcache;
    logic        arlock, awlock, arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    cbus_req_t   creqs  [2];
    cbus_resp_t  cresps [2];
    logic [1:0]  cerr;

    int ntot  = 0;
    int npass = 0;

`ifdef CBUS_AXI_ERR_EN
    localparam logic [1:0] CERR_EXP = 2'b10;
`else
    localparam logic [1:0] CERR_EXP = 2'b00;
`endif

    always #5 aclk = ~aclk;

    cbus_axi_arbiter #(.NUM_PORTS(2), .ID_BASE(2), .BURST(AXI_BURST_WRAP)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .creqs(creqs), .cresps(cresps), .cerr(cerr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int exp_port;
        areset  = 1'b1;
        arready = 0; awready = 0; wready = 0;
        rvalid = 0; rlast = 0; rdata = '0; rresp = '0; rid = '0;
        bvalid = 0; bresp = '0; bid = '0;
        creqs[0] = '0;
        creqs[1] = '0;
        creqs[0].valid = 1'b1;
        creqs[0].addr  = 64'h100;
        creqs[0].size  = 3'd3;

        // Reset held for three edges with port 0 requesting.
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            chk("rst_arvalid", 64'(arvalid), 64'd0);
            chk("rst_outputs", 64'({awvalid, wvalid, rready, bready, cresps[0].ready, cresps[1].ready}), 64'd0);
            chk("rst_araddr", araddr, 64'd0);
            chk("rst_cerr", 64'(cerr), 64'd0);
        end
        areset = 1'b0;
        settle();
        chk("ar_not_early", 64'(arvalid), 64'd0);
        cyc();
        settle();
        chk("ar_after_rst", 64'(arvalid), 64'd1);
        chk("ar_rst_id", 64'(arid), 64'd2);
        chk("ar_rst_addr", araddr, 64'h100);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        rvalid = 1'b1; rlast = 1'b1; rdata = 64'hA5;
        settle();
        chk("rd0_ready_last", 64'({cresps[0].ready, cresps[0].last}), 64'b11);
        chk("rd0_data", cresps[0].data, 64'hA5);
        cyc();
        creqs[0].valid = 1'b0;
        rvalid = 1'b0; rlast = 1'b0;

        // Port 1 read burst of four beats.
        creqs[1].valid = 1'b1;
        creqs[1].addr  = 64'h80001000;
        creqs[1].len   = 8'd3;
        creqs[1].size  = 3'd3;
        cyc();
        settle();
        chk("burst_arvalid", 64'(arvalid), 64'd1);
        chk("burst_arid", 64'(arid), 64'd3);
        chk("burst_arlen", 64'(arlen), 64'd3);
        chk("burst_arburst", 64'(arburst), 64'(AXI_BURST_WRAP));
        chk("burst_araddr", araddr, 64'h80001000);
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid = 1'b1;
            rlast  = (b == 3);
            rdata  = 64'h1000 + 64'(b);
            settle();
            chk("burst_ready", 64'(cresps[1].ready), 64'd1);
            chk("burst_last", 64'(cresps[1].last), 64'(b == 3));
            chk("burst_data", cresps[1].data, 64'h1000 + 64'(b));
            chk("burst_other_port", 64'(cresps[0].ready), 64'd0);
            cyc();
            if (b == 1) begin
                rvalid = 1'b0;
                settle();
                chk("burst_gap_ready", 64'(cresps[1].ready), 64'd0);
                chk("burst_gap_rready", 64'(rready), 64'd1);
                cyc();
            end
        end
        creqs[1].valid = 1'b0;
        rvalid = 1'b0; rlast = 1'b0;

        // Port 0 two-beat write with a late B response.
        creqs[0].valid    = 1'b1;
        creqs[0].is_write = 1'b1;
        creqs[0].addr     = 64'h2000;
        creqs[0].len      = 8'd1;
        creqs[0].data     = 64'hD0;
        creqs[0].strb     = 8'hFF;
        cyc();
        settle();
        chk("wr_awvalid", 64'(awvalid), 64'd1);
        chk("wr_arvalid", 64'(arvalid), 64'd0);
        chk("wr_awid", 64'(awid), 64'd2);
        chk("wr_awlen", 64'(awlen), 64'd1);
        chk("wr_awaddr", awaddr, 64'h2000);
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        wready  = 1'b1;
        settle();
        chk("wr_b0_wvalid_wlast", 64'({wvalid, wlast}), 64'b10);
        chk("wr_b0_wdata", wdata, 64'hD0);
        chk("wr_b0_wstrb", 64'(wstrb), 64'hFF);
        chk("wr_b0_ready", 64'({cresps[0].ready, cresps[0].last}), 64'b10);
        cyc();
        creqs[0].data = 64'hD1;
        settle();
        chk("wr_b1_wlast", 64'(wlast), 64'd1);
        chk("wr_b1_wdata", wdata, 64'hD1);
        chk("wr_b1_no_ready", 64'(cresps[0].ready), 64'd0);
        cyc();
        wready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("wr_wait_bready", 64'(bready), 64'd1);
            chk("wr_wait_ready", 64'({cresps[0].ready, cresps[0].last}), 64'd0);
            cyc();
        end
        bvalid = 1'b1;
        settle();
        chk("wr_b_ready_last", 64'({cresps[0].ready, cresps[0].last}), 64'b11);
        cyc();
        creqs[0] = '0;
        bvalid = 1'b0;
        settle();
        chk("wr_done_bready", 64'(bready), 64'd0);

        // Port 1 single-beat write answered with SLVERR.
        creqs[1] = '0;
        creqs[1].valid    = 1'b1;
        creqs[1].is_write = 1'b1;
        creqs[1].addr     = 64'h3000;
        creqs[1].data     = 64'hE1;
        creqs[1].strb     = 8'h0F;
        cyc();
        settle();
        chk("err_awid", 64'(awid), 64'd3);
        awready = 1'b1;
        cyc();
        awready = 1'b0;
        wready  = 1'b1;
        settle();
        chk("err_wlast", 64'(wlast), 64'd1);
        chk("err_wdata", wdata, 64'hE1);
        chk("err_w_no_ready", 64'(cresps[1].ready), 64'd0);
        cyc();
        wready = 1'b0;
        bvalid = 1'b1;
        bresp  = 2'b10;
        settle();
        chk("err_b_ready_last", 64'({cresps[1].ready, cresps[1].last}), 64'b11);
        cyc();
        creqs[1].valid = 1'b0;
        bvalid = 1'b0;
        bresp  = 2'b00;
        settle();
        chk("err_cerr_set", 64'(cerr), 64'(CERR_EXP));

        // Both ports continuously requesting single-beat reads from rr_ptr = 0.
        creqs[0] = '0;
        creqs[1] = '0;
        creqs[0].valid = 1'b1; creqs[0].addr = 64'h4000;
        creqs[1].valid = 1'b1; creqs[1].addr = 64'h5000;
        for (int k = 0; k < 4; k++) begin
            exp_port = k % 2;
            cyc();
            settle();
            chk("fair_arvalid", 64'(arvalid), 64'd1);
            chk("fair_arid", 64'(arid), 64'(2 + exp_port));
            chk("fair_araddr", araddr, (exp_port == 0) ? 64'h4000 : 64'h5000);
            arready = 1'b1;
            cyc();
            arready = 1'b0;
            rvalid = 1'b1; rlast = 1'b1; rdata = 64'h77 + 64'(k);
            settle();
            chk("fair_ready", 64'({cresps[exp_port].ready, cresps[exp_port].last}), 64'b11);
            chk("fair_idle_port", 64'(cresps[1 - exp_port].ready), 64'd0);
            cyc();
            rvalid = 1'b0; rlast = 1'b0;
        end
        creqs[0].valid = 1'b0;
        creqs[1].valid = 1'b0;
        settle();
        chk("fair_cerr_held", 64'(cerr), 64'(CERR_EXP));

        // Reset asserted during beat 2 of an eight-beat read.
        creqs[0].valid = 1'b1;
        creqs[0].addr  = 64'h6000;
        creqs[0].len   = 8'd7;
        cyc();
        arready = 1'b1;
        cyc();
        arready = 1'b0;
        rvalid = 1'b1; rlast = 1'b0; rdata = 64'h61;
        settle();
        chk("mid_beat1_ready", 64'(cresps[0].ready), 64'd1);
        cyc();
        rdata  = 64'h62;
        areset = 1'b1;
        settle();
        chk("mid_beat2_ready", 64'(cresps[0].ready), 64'd1);
        cyc();
        areset = 1'b0;
        creqs[0].valid = 1'b0;
        settle();
        chk("mid_rready", 64'(rready), 64'd0);
        chk("mid_cresps", 64'({cresps[0].ready, cresps[0].last}), 64'd0);
        chk("mid_cresps_data", cresps[0].data, 64'd0);
        chk("mid_cerr_cleared", 64'(cerr), 64'd0);
        cyc();
        rvalid = 1'b0;
        settle();
        chk("mid_stay_idle", 64'({arvalid, awvalid, rready}), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
